// File: rtl/modn_cnt_pkg.sv
// Shared definitions for the modulo-N up/down counter family.
// Holds direction encodings and the effective-modulus / terminal-value helpers
// used by both the counter top and its next-state logic.
package modn_cnt_pkg;

  // Direction encodings for the `up` input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Widest counter the helpers support. Callers zero-extend into this width
  // and cast the result back down to WIDTH+1 bits.
  localparam int MODN_MAX_W = 31;

  typedef logic [MODN_MAX_W:0] modn_wide_t;

  // Effective modulus: a programmed value of zero means 2^width, which needs
  // the extra top bit to be representable.
  function automatic modn_wide_t eff_mod(input logic [MODN_MAX_W-1:0] modv,
                                         input int unsigned           width);
    modn_wide_t r;
    if (modv == '0) r = modn_wide_t'(1) << width;
    else            r = {1'b0, modv};
    return r;
  endfunction

  // Terminal value of an up count (Me-1). Me is never zero, so no underflow.
  function automatic modn_wide_t term_val(input modn_wide_t me);
    return me - modn_wide_t'(1);
  endfunction

endpackage

// File: rtl/modn_next_state.sv
// Combinational next-count and terminal detection for modn_updown_counter.
// Given the current count, the effective modulus and the direction it
// produces the value the count takes on a step, whether the current count
// sits at the terminal value for that direction, and whether a step taken
// now is a wrap step.
module modn_next_state
  import modn_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH:0]   me,
  input  logic             up,
  input  logic             step,
  output logic [WIDTH-1:0] q_next,
  output logic             at_term,
  output logic             wrap_step
);

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] term;
  logic           q_zero;
  logic           at_top;
  logic           out_of_range;

  assign q_ext        = {1'b0, q};
  assign term         = (WIDTH+1)'(term_val(modn_wide_t'(me)));
  assign q_zero       = (q == '0);
  assign at_top       = (q_ext == term);
  // A count at or above Me can only come from a load or a live modulus
  // reduction; such counts recover to zero without signalling a wrap.
  assign out_of_range = (q_ext >= me);

  // Terminal value depends on direction: Me-1 counting up, 0 counting down.
  assign at_term   = (up == DIR_UP) ? at_top : q_zero;
  assign wrap_step = step & at_term;

  // Next count for a step. The terminal test is checked first so that Me=1
  // (terminal value 0 in both directions) keeps the count pinned at 0.
  always_comb begin
    q_next = q;
    if (up == DIR_UP) begin
      if (at_top)            q_next = '0;
      else if (out_of_range) q_next = '0;
      else                   q_next = q + WIDTH'(1);
    end else begin
      if (q_zero)            q_next = WIDTH'(term);
      else if (out_of_range) q_next = '0;
      else                   q_next = q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/modn_updown_counter.sv
// Parametrised modulo-N up/down counter with parallel load and cascade
// chaining (tc of one stage feeds carry_in of the next).
// Optional build macro MODN_CNT_SHADOW_EN: when defined, the modulus is
// sampled into a shadow register on clear and on every wrap step, so a
// modulus change only takes effect at the start of the next period. When
// undefined the live modulus input is used every cycle.
module modn_updown_counter
  import modn_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic             carry_in,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap
);

  logic             step;
  logic [WIDTH-1:0] mod_sel;
  logic [WIDTH:0]   me;
  logic [WIDTH-1:0] q_next;
  logic             at_term;
  logic             wrap_step;

  // Only the least-significant stage has carry_in tied high; upper stages
  // step solely when everything below them wraps on this edge.
  assign step = en & carry_in;

`ifdef MODN_CNT_SHADOW_EN
  logic [WIDTH-1:0] mod_shadow;

  // Capture the modulus at period boundaries; load leaves it untouched.
  always_ff @(posedge clock) begin
    if (clear)   mod_shadow <= modulus;
    else if (tc) mod_shadow <= modulus;
  end

  assign mod_sel = mod_shadow;
`else
  assign mod_sel = modulus;
`endif

  // Me in WIDTH+1 bits so that a programmed zero can mean 2^WIDTH.
  assign me = (WIDTH+1)'(eff_mod(MODN_MAX_W'(mod_sel), WIDTH));

  modn_next_state #(
    .WIDTH (WIDTH)
  ) u_next (
    .q         (q),
    .me        (me),
    .up        (up),
    .step      (step),
    .q_next    (q_next),
    .at_term   (at_term),
    .wrap_step (wrap_step)
  );

  // Terminal count is combinational so the next stage steps on the very
  // edge this stage wraps; clear and load suppress it since they win.
  assign tc = wrap_step & ~clear & ~load;

  // Count register: clear > load > step > hold.
  always_ff @(posedge clock) begin
    if (clear)     q <= '0;
    else if (load) q <= load_val;
    else if (step) q <= q_next;
  end

  // One-cycle pulse marking that the previous edge was a wrap step.
  always_ff @(posedge clock) begin
    if (clear) wrap <= 1'b0;
    else       wrap <= tc;
  end

  assign q_bar = ~q;

endmodule
